ram_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer in front of one 64x8 synchronous RAM (In/Address/ChipSelect/Write/Out).

---
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin sequencer driving one synchronous 64x8 RAM, one access every three cycles.
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t              state_q, state_d;
  logic                last_q, last_d, gid_q, gid_d, cs_q, cs_d, wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   in_q, in_d;
  logic                g0, g1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      in_q    <= in_d;
    end
  end
  // Grants are suppressed while reset is high so nothing is accepted into a flushed pipeline.
  always_comb begin
    g0 = !reset && state_q == IDLE && req0_valid && (!req1_valid || last_q);
    g1 = !reset && state_q == IDLE && req1_valid && (!req0_valid || !last_q);
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    in_d    = in_q;
    if (state_q == IDLE && (g0 || g1)) begin
      state_d = ACCESS;
      last_d  = g1;
      gid_d   = g1;
      cs_d    = 1'b1;
      wr_d    = g1 ? req1_write : req0_write;
      addr_d  = g1 ? req1_addr : req0_addr;
      in_d    = g1 ? req1_wdata : req0_wdata;
    end else if (state_q == ACCESS) begin
      state_d = RESP;
      cs_d    = 1'b0;
      wr_d    = 1'b0;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  // Chip select is masked by reset so an access edge under reset never commits a write.
  always_comb begin
    req0_ready = g0;
    req1_ready = g1;
    rsp0_valid = !reset && state_q == RESP && !gid_q;
    rsp1_valid = !reset && state_q == RESP && gid_q;
    rsp0_rdata = rsp0_valid ? ram_out : '0;
    rsp1_rdata = rsp1_valid ? ram_out : '0;
    ram_cs     = cs_q && !reset;
    ram_write  = wr_q;
    ram_addr   = addr_q;
    ram_in     = in_q;
    busy       = state_q != IDLE;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed stimulus against a transaction-level model with a response scoreboard.
module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [5:0] req0_addr = 0, req1_addr = 0;
  logic [7:0] req0_wdata = 0, req1_wdata = 0;
  logic       req0_ready, rsp0_valid, req1_ready, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata, ram_in;
  logic [5:0] ram_addr;
  logic       ram_cs, ram_write, busy;
  logic [7:0] ram_out = 8'h00;
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  int         tests = 0, fails = 0;
  typedef struct packed {logic id; logic [7:0] data;} rsp_t;
  rsp_t       exp_q[$];
  int         cnt = 0;
  logic       last = 1'b1;
  logic       p_id, p_wr;
  logic [5:0] p_addr;
  logic [7:0] p_wd;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_in(ram_in), .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_write(ram_write),
    .ram_out(ram_out), .busy(busy)
  );

  // Synchronous RAM: write-then-read-back, registered output.
  always @(posedge clk)
    if (ram_cs) begin
      if (ram_write) mem[ram_addr] <= ram_in;
      ram_out <= ram_write ? ram_in : mem[ram_addr];
    end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: idle / access / response phases, round-robin on ties, writes commit at access.
  always @(negedge clk) begin
    logic e0, e1;
    if (reset) begin
      chk("ready0_rst", req0_ready, 0);
      chk("ready1_rst", req1_ready, 0);
      chk("rsp_rst", rsp0_valid | rsp1_valid, 0);
      chk("cs_rst", ram_cs, 0);
      cnt = 0;
      last = 1'b1;
      exp_q.delete();
    end else begin
      e0 = cnt == 0 && req0_valid && (!req1_valid || last);
      e1 = cnt == 0 && req1_valid && (!req0_valid || !last);
      chk("busy", busy, cnt != 0);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("ram_cs", ram_cs, cnt == 2);
      chk("rsp_strobe", rsp0_valid | rsp1_valid, cnt == 1);
      if (cnt == 2) begin
        if (p_wr) ref_mem[p_addr] = p_wd;
        exp_q.push_back({p_id, ref_mem[p_addr]});
      end
      if (e0 || e1) begin
        p_id   = e1;
        p_wr   = e1 ? req1_write : req0_write;
        p_addr = e1 ? req1_addr : req0_addr;
        p_wd   = e1 ? req1_wdata : req0_wdata;
        last   = e1;
        cnt    = 2;
      end else if (cnt > 0) cnt--;
    end
  end

  // Scoreboard monitor: pops the expected response whenever the DUT strobes one.
  always @(negedge clk) begin
    rsp_t e;
    if (!rsp0_valid && rsp0_rdata != 0) chk("rdata0_idle", rsp0_rdata, 0);
    if (!rsp1_valid && rsp1_rdata != 0) chk("rdata1_idle", rsp1_rdata, 0);
    if (rsp0_valid || rsp1_valid) begin
      chk("rsp_onehot", rsp0_valid & rsp1_valid, 0);
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp1_valid, e.id);
        chk("rsp_data", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.data);
      end
    end
  end

  task automatic tick(input bit r, input bit v0, input bit w0, input logic [5:0] a0, input logic [7:0] d0,
                      input bit v1, input bit w1, input logic [5:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    reset = r;
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    tick(0, 1, 1, 6'h05, 8'hA5, 0, 0, 0, 0);
    idle(3);
    tick(0, 0, 0, 0, 0, 1, 0, 6'h05, 8'h00);
    idle(3);
    for (int i = 0; i < 12; i++) tick(0, 1, 1, 6'h10, 8'h11, 1, 1, 6'h20, 8'h22);
    idle(3);
    tick(0, 1, 1, 6'h3F, 8'hFF, 0, 0, 0, 0);
    idle(2);
    tick(0, 0, 0, 0, 0, 1, 0, 6'h3F, 8'h00);
    idle(2);
    tick(0, 1, 0, 6'h00, 8'h00, 0, 0, 0, 0);
    idle(3);
    tick(0, 1, 1, 6'h07, 8'h77, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 6'h07, 8'h00, 1, 0, 6'h07, 8'h00);
    idle(3);
    tick(0, 1, 1, 6'h30, 8'h3C, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 1, 6'h31, 8'h5A);
    tick(0, 1, 1, 6'h32, 8'h66, 1, 0, 6'h30, 8'h00);
    idle(3);
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           6'($urandom_range(0, 63)), 8'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0 ? 6'h3F : 6'($urandom_range(0, 7)), 8'($urandom));
    idle(5);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
